aes_multi_key_iter: RTL
=======================

Name: aes_multi_key_iter

Overview:
- Iterative AES-128/192/256 encryption core, one round per clock.
- Key length is selected per block at runtime, generalising the fixed-192 fully unrolled pipeline.
- On-the-fly key expansion from a sliding 8-word window; valid/ready handshakes on input and output.
- Sits between a DMA/CSR front end and a ciphertext sink wherever area matters more than throughput.

Parameters:
- KLEN_ALLOW, 3'b111, bitmask of permitted key lengths: bit0=128, bit1=192, bit2=256.
- ERR_ZERO_OUT, 1, when 1, rejected requests return out_data=0; when 0, they return in_data unchanged.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  core can accept a request
- in_data  input  128  plaintext, byte 0 in [127:120]
- in_key  input  256  key, left-aligned: 128-bit key in [255:128], 192-bit key in [255:64]
- in_klen  input  2  0=128, 1=192, 2=256, 3=reserved
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_data  output  128  ciphertext
- out_err  output  1  request was rejected (reserved or disallowed klen)
- blk_cnt  output  32  completed-block counter (only with AES_BLK_CNT_EN)

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst_i.
- Reset values: in_ready=0 in the reset cycle, then 1; out_valid=0; out_data=0; out_err=0; blk_cnt=0; FSM state IDLE.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&in_ready (cycle T):
  - Good klen: state <= in_data ^ in_key[255:128]; key window <= in_key; Nr <= 10/12/14; rnd <= 1; go to ROUND.
  - Bad klen: out_err <= 1; out_data per ERR_ZERO_OUT; go directly to DONE; out_valid high in cycle T+1.
- ROUND: in_ready=0. Each cycle applies SubBytes, ShiftRows, MixColumns and AddRoundKey(rk[rnd]), then rnd++.
  - When rnd==Nr, MixColumns is omitted, the result goes to out_data, out_err=0, and the FSM goes to DONE.
  - out_valid rises in cycle T+Nr+1.
- Key expansion: each cycle produces the next 4 words w[4r..4r+3] from the previous Nk words (Nk=4/6/8), chaining within the cycle.
  - RotWord+SubWord+Rcon applies when i mod Nk==0.
  - SubWord only applies when Nk==8 and i mod 8==4.
  - Rcon index = i/Nk; Rcon sequence 01,02,04,08,10,20,40,80,1b,36.
- DONE: out_valid=1; out_data and out_err stay stable until out_ready. On out_valid&out_ready, go to IDLE; in_ready=1 the following cycle.
- No overlap: in_ready=0 in ROUND and DONE. Throughput is one block per Nr+2 cycles with out_ready tied high.
- Inputs are sampled only at handshake; changes to in_key or in_data mid-operation have no effect.
- rst_i mid-operation: abort, go to IDLE next cycle, out_valid=0, result discarded, blk_cnt reset.
- out_ready is ignored when out_valid=0.

Optional Feature:
- Macro AES_BLK_CNT_EN.
- Defined: blk_cnt port present. It increments by 1 on every output handshake with out_err=0, saturates at 32'hFFFF_FFFF and clears only on rst_i.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package aes_iter_pkg holds:
  - klen_e enum (KLEN_128, KLEN_192, KLEN_256, KLEN_RSVD)
  - nr_of(klen) and nk_of(klen) functions
  - RCON constant array
  - sbox byte function
  - xtime / MixColumns function
  - FSM state enum
- One sub-module: aes_key_step. Combinational; takes the 8-word window, Nk and the current word index; outputs the next window and the 128-bit round key.

Test Plan:
- AES-128 FIPS-197 C.1: key 000102…0f, klen=0, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at T+11, out_err=0.
- AES-192 C.2: key 000102…17, klen=1, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 at T+13.
- AES-256 C.3: key 000102…1f, klen=2, same pt -> 8ea2b7ca516745bfeafc49904b496089 at T+15.
- Error path:
  - klen=3 -> out_valid at T+1, out_err=1, out_data=0.
  - KLEN_ALLOW=3'b011 with klen=2 -> same error response.
- Backpressure: out_ready held low 20 cycles after the C.1 result -> out_data stable, in_ready=0 throughout; after the handshake, in_ready=1 next cycle. Three back-to-back mixed-klen blocks all correct; blk_cnt=3 with AES_BLK_CNT_EN.
- Reset mid-run: rst_i pulsed at rnd=5 of an AES-256 block -> next cycle IDLE, out_valid=0, in_ready=1 after reset deasserts; a new C.1 request then yields the correct result.

Source files
------------

// File: rtl/aes_iter_pkg.sv
// Shared types, constants and byte-level AES helpers for the iterative
// multi-key-length AES encryption core.
package aes_iter_pkg;

  typedef enum logic [1:0] {KLEN_128, KLEN_192, KLEN_256, KLEN_RSVD} klen_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_e;

  // Byte n of a block lives at bits [127-8n -: 8], so column c is bytes 4c..4c+3.
  typedef logic [0:15][7:0] blk_t;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nr_of(input klen_e klen);
    case (klen)
      KLEN_128: return 4'd10;
      KLEN_192: return 4'd12;
      default:  return 4'd14;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input klen_e klen);
    case (klen)
      KLEN_128: return 4'd4;
      KLEN_192: return 4'd6;
      default:  return 4'd8;
    endcase
  endfunction

  // Right-align the key words so the most recent word always sits in slot 7.
  function automatic logic [255:0] align_key(input logic [255:0] key, input klen_e klen);
    case (klen)
      KLEN_128: return {128'h0, key[255:128]};
      KLEN_192: return {64'h0, key[255:64]};
      default:  return key;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] q);
    logic [3:0] n;
    n = q[3:0] - 4'd1;
    if (q >= 6'd1 && q <= 6'd10) return RCON[n];
    return 8'h00;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic blk_t sub_bytes(input blk_t s);
    blk_t r;
    for (int n = 0; n < 16; n++) r[n] = sbox(s[n]);
    return r;
  endfunction

  function automatic blk_t shift_rows(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        r[rr + 4*c] = s[rr + 4*((c + rr) % 4)];
    return r;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t r;
    for (int c = 0; c < 4; c++)
      {r[4*c], r[4*c+1], r[4*c+2], r[4*c+3]} =
        mix_column({s[4*c], s[4*c+1], s[4*c+2], s[4*c+3]});
    return r;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of on-the-fly key expansion: four new words per call, chained,
// from a right-aligned 8-word window of the most recent key words.
module aes_key_step
  import aes_iter_pkg::*;
(
  input  logic [255:0] win,
  input  logic [3:0]   nk,
  input  logic [5:0]   idx,
  output logic [255:0] win_next,
  output logic [127:0] rkey
);

  logic [0:11][31:0] words;

  // Slots 0..7 hold w[idx-8..idx-1]; slots 8..11 receive w[idx..idx+3].
  function automatic logic [0:11][31:0] expand(input logic [255:0] w,
                                              input logic [3:0] nk_v,
                                              input logic [5:0] base);
    logic [0:11][31:0] c;
    logic [31:0] t;
    logic [5:0]  i, q, r;
    c = {w, 128'h0};
    for (int j = 0; j < 4; j++) begin
      i = base + 6'(j);
      case (nk_v)
        4'd4:    begin q = {2'b00, i[5:2]}; r = {4'b0000, i[1:0]}; end
        4'd6:    begin q = i / 6'd6; r = i % 6'd6; end
        default: begin q = {3'b000, i[5:3]}; r = {3'b000, i[2:0]}; end
      endcase
      t = c[7+j];
      if (r == 6'd0)
        t = sub_word(rot_word(t)) ^ {rcon(q), 24'h0};
      else if (nk_v == 4'd8 && r == 6'd4)
        t = sub_word(t);
      c[8+j] = c[8 + j - int'(nk_v)] ^ t;
    end
    return c;
  endfunction

  // The round key trails the newest word by Nk-4 words.
  always_comb begin
    words    = expand(win, nk, idx);
    win_next = words[4:11];
    case (nk)
      4'd4:    rkey = words[8:11];
      4'd6:    rkey = words[6:9];
      default: rkey = words[4:7];
    endcase
  end

endmodule

// File: rtl/aes_multi_key_iter.sv
// Iterative AES-128/192/256 encryption, one round per clock, key length per block.
// Optional AES_BLK_CNT_EN adds a saturating completed-block counter on blk_cnt.
module aes_multi_key_iter
  import aes_iter_pkg::*;
#(
  parameter logic [2:0] KLEN_ALLOW   = 3'b111,
  parameter bit         ERR_ZERO_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [255:0] in_key,
  input  logic [1:0]   in_klen,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_err
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and out_data/out_err hold while
  // out_valid is high and out_ready is low.

  state_e        fsm_q, fsm_d;
  logic [127:0]  st_q;
  logic [255:0]  win_q, win_nxt;
  logic [5:0]    idx_q;
  logic [3:0]    nk_q, nr_q, rnd_q;
  logic [127:0]  rkey, rnd_out;
  blk_t          sr, mc;
  logic [3:0]    allow_mask;
  logic          klen_ok, accept, last_rnd;
  klen_e         klen;

  assign klen       = klen_e'(in_klen);
  assign allow_mask = {1'b0, KLEN_ALLOW};
  assign klen_ok    = allow_mask[in_klen];
  assign accept     = in_valid & in_ready;
  assign last_rnd   = (rnd_q == nr_q);

  aes_key_step u_key_step (
    .win      (win_q),
    .nk       (nk_q),
    .idx      (idx_q),
    .win_next (win_nxt),
    .rkey     (rkey)
  );

  always_comb begin
    sr      = shift_rows(sub_bytes(st_q));
    mc      = mix_columns(sr);
    rnd_out = (last_rnd ? sr : mc) ^ rkey;
  end

  always_ff @(posedge clk) begin
    if (rst_i) fsm_q <= ST_IDLE;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        in_ready = ~rst_i;
        if (accept) fsm_d = klen_ok ? ST_ROUND : ST_DONE;
      end
      ST_ROUND: begin
        if (last_rnd) fsm_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      st_q     <= '0;
      win_q    <= '0;
      idx_q    <= '0;
      nk_q     <= 4'd4;
      nr_q     <= 4'd10;
      rnd_q    <= '0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (accept) begin
            if (klen_ok) begin
              st_q  <= in_data ^ in_key[255:128];
              win_q <= align_key(in_key, klen);
              idx_q <= {2'b00, nk_of(klen)};
              nk_q  <= nk_of(klen);
              nr_q  <= nr_of(klen);
              rnd_q <= 4'd1;
            end else begin
              out_err  <= 1'b1;
              out_data <= ERR_ZERO_OUT ? 128'h0 : in_data;
            end
          end
        end
        ST_ROUND: begin
          st_q  <= rnd_out;
          win_q <= win_nxt;
          idx_q <= idx_q + 6'd4;
          rnd_q <= rnd_q + 4'd1;
          if (last_rnd) begin
            out_data <= rnd_out;
            out_err  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef AES_BLK_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_i)
      blk_cnt <= '0;
    else if (out_valid && out_ready && !out_err && blk_cnt != 32'hFFFF_FFFF)
      blk_cnt <= blk_cnt + 32'd1;
  end
`endif

endmodule
